// File: rtl/uart_receiver.sv
// UART receive engine: 2-flop synchroniser, 16x NCO oversampling, 2-of-3 majority voting,
// and a byte hold register with valid/ack handshake and frame/parity/overrun flags.
module uart_receiver #(
    parameter int unsigned DEFAULT_BDR  = 115200,
    parameter int unsigned SYS_CLK_DIV2 = 50_000_000,
    parameter int unsigned PARITY_BIT   = 3,
    parameter int unsigned STOP_BIT     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    output logic       busy
);
    localparam logic [63:0] INC_WIDE =
        (64'(DEFAULT_BDR) * 64'd16 * 64'd65536) / 64'(SYS_CLK_DIV2);
    localparam logic [15:0] INC = INC_WIDE[15:0];

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Mark mode mirrors the transmitter, which always sends a 1 in the slot.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        case (PARITY_BIT)
            32'd1:   return (^d) ^ p;
            32'd2:   return ~((^d) ^ p);
            32'd3:   return ~p;
            default: return 1'b0;
        endcase
    endfunction

    state_t      state_r;
    logic        sync1_r, rxs_r, rxs_prev_r;
    logic [15:0] acc_r;
    logic [3:0]  cnt_r;
    logic        samp7_r, samp8_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_idx_r;
    logic        stop_idx_r;
    logic        frm_flag_r, par_flag_r;
    logic        commit_r;

    logic [16:0] sum_s;
    logic        tick_s, decide_s, wrap_s, maj_s, last_stop_s;

    assign sum_s       = {1'b0, acc_r} + {1'b0, INC};
    assign tick_s      = sum_s[16];
    assign decide_s    = tick_s && (cnt_r == 4'd9);
    assign wrap_s      = tick_s && (cnt_r == 4'd15);
    assign maj_s       = maj3(samp7_r, samp8_r, rxs_r);
    assign last_stop_s = (STOP_BIT == 32'd1) || stop_idx_r;

    // Synchroniser and edge history, reset high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            sync1_r    <= rxd;
            rxs_r      <= sync1_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Frame FSM with NCO, sample counter, majority samples and internal error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            acc_r      <= 16'd0;
            cnt_r      <= 4'd0;
            samp7_r    <= 1'b0;
            samp8_r    <= 1'b0;
            shift_r    <= 8'd0;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            frm_flag_r <= 1'b0;
            par_flag_r <= 1'b0;
            commit_r   <= 1'b0;
        end else begin
            commit_r <= 1'b0;
            if (commit_r) begin
                frm_flag_r <= 1'b0;
                par_flag_r <= 1'b0;
            end
            if (state_r == ST_IDLE) begin
                acc_r <= 16'd0;
                cnt_r <= 4'd0;
            end else begin
                acc_r <= sum_s[15:0];
                if (tick_s) cnt_r <= cnt_r + 4'd1;
                if (tick_s && (cnt_r == 4'd7)) samp7_r <= rxs_r;
                if (tick_s && (cnt_r == 4'd8)) samp8_r <= rxs_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rxs_prev_r && !rxs_r) begin
                        state_r <= ST_START;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (decide_s && maj_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (wrap_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (decide_s) shift_r <= {maj_s, shift_r[7:1]};
                    if (wrap_s) begin
                        if (bit_idx_r == 3'd7) begin
                            state_r    <= (PARITY_BIT != 32'd0) ? ST_PARITY : ST_STOP;
                            stop_idx_r <= 1'b0;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_s && parity_bad(shift_r, maj_s)) par_flag_r <= 1'b1;
                    if (wrap_s) begin
                        state_r    <= ST_STOP;
                        stop_idx_r <= 1'b0;
                    end
                end
                ST_STOP: begin
                    // Finish at mid-bit of the last stop so the next start edge is never missed
                    if (decide_s) begin
                        if (!maj_s) frm_flag_r <= 1'b1;
                        if (last_stop_s) begin
                            state_r  <= ST_IDLE;
                            busy     <= 1'b0;
                            commit_r <= 1'b1;
                        end
                    end
                    if (wrap_s) stop_idx_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Hold register and handshake; a commit wins over an ack in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else if (commit_r) begin
            rx_data     <= shift_r;
            rx_valid    <= 1'b1;
            frame_err   <= frm_flag_r;
            parity_err  <= par_flag_r;
            overrun_err <= rx_valid & ~rx_ack;
        end else if (rx_ack && rx_valid) begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end
    end
endmodule
